spi_flash_loader: RTL and testbench

- Boot-time streamer that wakes the on-board SPI flash and reads the Hack program image from it.
- Presents the image as a sequence of 16-bit instruction words with addresses, over a valid/ready handshake.
- Sits directly upstream of the instruction ROM store: its word stream fills program memory, and `done` releases the CPU from reset.

---
 rtl/spi_flash_loader_if.sv | 25 ++
 rtl/spi_flash_loader.sv | 185 ++++++++++++++++++
 tb/tb_spi_flash_loader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_loader_if.sv
// Word stream from the SPI flash loader into program memory.
// The loader drives the master side; the ROM store and reset release logic sit on the slave side.
interface spi_flash_loader_if;
  logic [15:0] word_data;
  logic [15:0] word_addr;
  logic        word_valid;
  logic        word_ready;
  logic        done;

  modport master (
    output word_data,
    output word_addr,
    output word_valid,
    output done,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_addr,
    input  word_valid,
    input  done,
    output word_ready
  );
endinterface

// File: rtl/spi_flash_loader.sv
// Boot streamer: wakes the SPI flash, issues one continuous read and hands the Hack image
// out as 16-bit words over valid/ready, asserting done once the last word is taken.
module spi_flash_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter logic [16:0] WORDS        = 17'h08000,
  parameter logic [15:0] WAKE_CYCLES  = 16'd200
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  spi_flash_loader_if.master  word,
  output logic                spi_cs,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    WAKE_CMD,
    WAKE_WAIT,
    READ_CMD,
    READ_WORD,
    HOLD,
    DONE
  } state_e;

  localparam logic [31:0] WAKE_FRAME = {8'hAB, 24'h000000};
  localparam logic [31:0] READ_FRAME = {8'h03, FLASH_OFFSET};
  localparam logic [15:0] LAST_ADDR  = 16'(WORDS - 17'd1);
  localparam logic [15:0] WAIT_LAST  = WAKE_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [31:0] tx_q, tx_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [4:0]  lastBit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      bitCnt_q  <= '0;
      waitCnt_q <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      bitCnt_q  <= bitCnt_d;
      waitCnt_q <= waitCnt_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    bitCnt_d  = bitCnt_q;
    waitCnt_d = waitCnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    done_d    = done_q;
    lastBit   = (state_q == WAKE_CMD) ? 5'd7 : 5'd31;

    case (state_q)
      IDLE: begin
        if (clken) begin
          cs_d     = 1'b0;
          mosi_d   = WAKE_FRAME[31];
          tx_d     = WAKE_FRAME << 1;
          bitCnt_d = '0;
          state_d  = WAKE_CMD;
        end
      end

      // Each bit is a low phase (mosi already set) followed by a high phase; the next bit
      // is presented on the edge that ends the high phase.
      WAKE_CMD, READ_CMD: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bitCnt_q == lastBit) begin
          sclk_d   = 1'b0;
          mosi_d   = 1'b0;
          bitCnt_d = '0;
          if (state_q == WAKE_CMD) begin
            cs_d      = 1'b1;
            waitCnt_d = '0;
            state_d   = WAKE_WAIT;
          end else begin
            state_d = READ_WORD;
          end
        end else begin
          sclk_d   = 1'b0;
          mosi_d   = tx_q[31];
          tx_d     = tx_q << 1;
          bitCnt_d = bitCnt_q + 5'd1;
        end
      end

      WAKE_WAIT: begin
        if (waitCnt_q == WAIT_LAST) begin
          cs_d     = 1'b0;
          mosi_d   = READ_FRAME[31];
          tx_d     = READ_FRAME << 1;
          bitCnt_d = '0;
          state_d  = READ_CMD;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end

      // miso is captured on the edge that ends the high phase, first bit landing in [15].
      READ_WORD: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          data_d = {data_q[14:0], spi_miso};
          if (bitCnt_q == 5'd15) begin
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end

      // cs stays low so the flash keeps its read pointer while the consumer stalls.
      HOLD: begin
        if (word.word_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + 16'd1;
          if (addr_q == LAST_ADDR) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            bitCnt_d = '0;
            state_d  = READ_WORD;
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi_cs          = cs_q;
  assign spi_sclk        = sclk_q;
  assign spi_mosi        = mosi_q;
  assign word.word_data  = data_q;
  assign word.word_addr  = addr_q;
  assign word.word_valid = valid_q;
  assign word.done       = done_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: a behavioural SPI flash serves a byte image, and the accepted
// word stream, command framing and SPI pin behaviour are compared against the image.
module tb_spi_flash_loader;

  localparam logic [23:0] OFFSET  = 24'h100000;
  localparam int          NWORDS  = 8;
  localparam int          WAKE    = 20;
  localparam int          PERIOD  = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_flash_loader_if word();

  spi_flash_loader #(
    .FLASH_OFFSET (OFFSET),
    .WORDS        (17'(NWORDS)),
    .WAKE_CYCLES  (16'(WAKE))
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .word     (word),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] image [0:255];
  int         readyMode = 0;

  // Flash model state, owned by the flash process.
  logic [7:0]  mosiLog [$];
  int          txnRises [$];
  time         csRiseT [$];
  time         csFallT [$];
  logic        csPrev, sclkPrev;
  int          rxBits = 0;
  int          dataBit = 0;
  int          flashIdx;
  logic [31:0] rxShift = '0;
  logic [7:0]  rxCmd = '0;
  logic [23:0] rxAddr = '0;
  int          sclkRisesTotal = 0;
  int          sclkWhileCsHigh = 0;

  // Stream monitor state, owned by the monitor process.
  logic [31:0] acc [$];
  int          stableErr = 0;
  int          gapErr = 0;
  int          cycleCnt = 0;
  int          lastRise = -1;
  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic [15:0] prevData = '0;
  logic [15:0] prevAddr = '0;
  int          doneRises = 0;

  // Flash: logs command bytes on rising sclk, shifts image bits out on falling sclk.
  always @(spi_cs or spi_sclk) begin
    if (spi_cs !== csPrev) begin
      if (spi_cs === 1'b0) begin
        rxBits  = 0;
        dataBit = 0;
        csFallT.push_back($time);
      end else if (spi_cs === 1'b1) begin
        txnRises.push_back(rxBits);
        csRiseT.push_back($time);
      end
    end
    if (spi_sclk !== sclkPrev) begin
      if (spi_sclk === 1'b1) begin
        sclkRisesTotal++;
        if (spi_cs !== 1'b0) begin
          sclkWhileCsHigh++;
        end else begin
          rxShift = {rxShift[30:0], spi_mosi};
          rxBits++;
          if (rxBits % 8 == 0 && rxBits <= 32) mosiLog.push_back(rxShift[7:0]);
          if (rxBits == 8) rxCmd = rxShift[7:0];
          if (rxBits == 32) rxAddr = rxShift[23:0];
        end
      end else if (spi_sclk === 1'b0 && spi_cs === 1'b0 && rxBits >= 32 && rxCmd == 8'h03) begin
        flashIdx = int'(rxAddr - OFFSET) + dataBit / 8;
        spi_miso = (flashIdx >= 0 && flashIdx < 256) ? image[flashIdx][7 - dataBit % 8] : 1'b0;
        dataBit++;
      end
    end
    csPrev   = spi_cs;
    sclkPrev = spi_sclk;
  end

  always @(negedge clk) begin
    cycleCnt++;
    if (reset_n !== 1'b1) begin
      prevValid = 1'b0;
      lastRise  = -1;
    end else begin
      if (word.word_valid && !prevValid) begin
        if (lastRise >= 0 && cycleCnt - lastRise < 33) gapErr++;
        lastRise = cycleCnt;
      end
      if (prevValid && !prevReady &&
          (!word.word_valid || word.word_data != prevData || word.word_addr != prevAddr))
        stableErr++;
      if (word.word_valid && word.word_ready) acc.push_back({word.word_addr, word.word_data});
      prevValid = word.word_valid;
      prevReady = word.word_ready;
      prevData  = word.word_data;
      prevAddr  = word.word_addr;
    end
  end

  always @(posedge word.done) doneRises++;

  always @(posedge clk) begin
    #1;
    if (readyMode == 2) word.word_ready = 1'($urandom_range(0, 1));
    else                word.word_ready = (readyMode == 1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput(tag, {spi_cs, spi_sclk, spi_mosi, word.word_valid, word.done, word.word_data, word.word_addr},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
  endtask

  // Resets the DUT, loads the image (known header or fully random) and selects the ready pattern.
  task automatic applyStimulus(input int readyPattern, input bit fullyRandom, input string tag);
    reset_n   = 1'b0;
    clken     = 1'b0;
    readyMode = readyPattern;
    for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
    if (!fullyRandom) begin
      image[0] = 8'h12;
      image[1] = 8'h34;
      image[2] = 8'hAB;
      image[3] = 8'hCD;
    end
    @(negedge clk);
    checkResetState({tag, "_reset"});
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (word.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitValid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (word.word_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compareStream(input int base, input string tag);
    logic [31:0] obs;
    logic [31:0] exp;
    checkOutput({tag, "_count"}, 64'(acc.size() - base), 64'(NWORDS));
    for (int i = 0; i < NWORDS; i++) begin
      exp = {16'(i), image[2 * i], image[2 * i + 1]};
      obs = (base + i < acc.size()) ? acc[base + i] : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_w%0d", tag, i), obs, exp);
    end
  endtask

  initial begin
    bit          ok;
    int          base, mBase, rBase, fBase, riseBase, sclkBase, hiBase, doneBase, stBase, gBase;
    int          bad, wakeHigh;
    logic [7:0]  expFrame [5];
    expFrame = '{8'hAB, 8'h03, 8'h10, 8'h00, 8'h00};

    // Run 1: start gating, framing, backpressure on word 0, then free flow.
    applyStimulus(0, 1'b0, "run1");
    base     = acc.size();
    mBase    = mosiLog.size();
    rBase    = txnRises.size();
    fBase    = csFallT.size();
    riseBase = csRiseT.size();
    sclkBase = sclkRisesTotal;
    hiBase   = sclkWhileCsHigh;
    doneBase = doneRises;
    stBase   = stableErr;
    gBase    = gapErr;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (spi_cs !== 1'b1) bad++;
    end
    checkOutput("gate_cs_high", 64'(bad), 64'd0);
    checkOutput("gate_no_sclk", 64'(sclkRisesTotal - sclkBase), 64'd0);

    @(posedge clk);
    #1 clken = 1'b1;
    checkOutput("start_cs_before", 64'(spi_cs), 64'd1);
    @(posedge clk);
    #1 checkOutput("start_cs_low", 64'(spi_cs), 64'd0);
    repeat (3) @(posedge clk);
    #1 clken = 1'b0;

    waitValid(2000, ok);
    checkOutput("w0_valid_seen", 64'(ok), 64'd1);
    checkOutput("w0_data", 64'(word.word_data), 64'h1234);
    checkOutput("w0_addr", 64'(word.word_addr), 64'h0000);

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(word.word_valid === 1'b1 && word.word_data === 16'h1234 &&
            spi_sclk === 1'b0 && spi_cs === 1'b0)) bad++;
    end
    checkOutput("backpressure_hold", 64'(bad), 64'd0);

    readyMode = 1;
    waitDone(3000, ok);
    checkOutput("run1_done_seen", 64'(ok), 64'd1);
    @(negedge clk);
    checkOutput("run1_end_cs", 64'(spi_cs), 64'd1);
    checkOutput("run1_end_sclk", 64'(spi_sclk), 64'd0);
    checkOutput("run1_end_addr", 64'(word.word_addr), 64'(NWORDS));
    compareStream(base, "run1");

    checkOutput("frame_len", 64'(mosiLog.size() - mBase), 64'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("frame_b%0d", i),
                  64'((mBase + i < mosiLog.size()) ? mosiLog[mBase + i] : 8'hxx), 64'(expFrame[i]));

    checkOutput("wake_sclk_rises", 64'((rBase < txnRises.size()) ? txnRises[rBase] : -1), 64'd8);
    checkOutput("read_sclk_rises", 64'((rBase + 1 < txnRises.size()) ? txnRises[rBase + 1] : -1),
                64'(32 + 16 * NWORDS));
    wakeHigh = (fBase + 1 < csFallT.size() && riseBase < csRiseT.size())
               ? int'((csFallT[fBase + 1] - csRiseT[riseBase]) / PERIOD) : -1;
    checkOutput("wake_cs_high_cycles", 64'(wakeHigh), 64'(WAKE));
    checkOutput("run1_sclk_cs_high", 64'(sclkWhileCsHigh - hiBase), 64'd0);
    checkOutput("run1_stable", 64'(stableErr - stBase), 64'd0);
    checkOutput("run1_gap", 64'(gapErr - gBase), 64'd0);
    checkOutput("run1_done_once", 64'(doneRises - doneBase), 64'd1);

    sclkBase = sclkRisesTotal;
    repeat (20) @(negedge clk);
    checkOutput("done_no_spi", 64'(sclkRisesTotal - sclkBase), 64'd0);
    checkOutput("done_sticky", 64'(word.done), 64'd1);

    // Run 2: random image with random consumer backpressure.
    applyStimulus(2, 1'b1, "run2");
    base     = acc.size();
    hiBase   = sclkWhileCsHigh;
    doneBase = doneRises;
    stBase   = stableErr;
    gBase    = gapErr;
    clken    = 1'b1;
    waitDone(6000, ok);
    checkOutput("run2_done_seen", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    compareStream(base, "run2");
    checkOutput("run2_end_addr", 64'(word.word_addr), 64'(NWORDS));
    checkOutput("run2_done_once", 64'(doneRises - doneBase), 64'd1);
    checkOutput("run2_stable", 64'(stableErr - stBase), 64'd0);
    checkOutput("run2_gap", 64'(gapErr - gBase), 64'd0);
    checkOutput("run2_sclk_cs_high", 64'(sclkWhileCsHigh - hiBase), 64'd0);

    // Run 3: reset while word 1 is being shifted in, then a clean restart.
    applyStimulus(1, 1'b0, "run3");
    base  = acc.size();
    clken = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (acc.size() > base) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("run3_w0_accepted", 64'(ok), 64'd1);
    repeat (8) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 checkResetState("midstream_async_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base     = acc.size();
    doneBase = doneRises;
    waitDone(3000, ok);
    checkOutput("run3_done_seen", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    compareStream(base, "run3");
    checkOutput("run3_done_once", 64'(doneRises - doneBase), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
